uart_recv: RTL and testbench

Serial receiver paired with uart_send. It deserialises 8N1 frames from RXD: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), idle-high line. Bit timing comes from a CLK-synchronous oversampling enable (UART_CLK_X16) produced by the shared clock divider at OVERSAMPLE × baud. Received bytes are presented on DATA with a one-CLK DATA_READY pulse for downstream consumers (command decoder / FIFO).

---
 rtl/uart_recv.sv | 186 ++++++++++++++++++
 tb/tb_uart_recv.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// 8N1 UART receiver: mid-bit sampling driven by an oversampling enable.
// Delivers each well-framed byte on DATA with a one-cycle DATA_READY pulse.
module uart_recv #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UART_CLK_X16,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       DATA_READY,
    output logic       FRAME_ERR,
    output logic       IDLE
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] MID_START = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] MID_BIT   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bitcnt;
    logic [7:0]       r_shreg;
    logic [7:0]       r_data;
    logic             r_ready;
    logic             r_ferr;
    logic             r_idle;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bitcnt_nxt;
    logic [7:0]       w_shreg_nxt;
    logic [7:0]       w_data_nxt;
    logic             w_ready_nxt;
    logic             w_ferr_nxt;
    logic             w_rxd_s;

    assign w_rxd_s = r_sync2;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RXD;
            r_sync2 <= r_sync1;
        end
    end

    // State, datapath and registered output update.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= CNT_ZERO;
            r_bitcnt <= 3'd0;
            r_shreg  <= 8'h00;
            r_data   <= 8'h00;
            r_ready  <= 1'b0;
            r_ferr   <= 1'b0;
            r_idle   <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shreg  <= w_shreg_nxt;
            r_data   <= w_data_nxt;
            r_ready  <= w_ready_nxt;
            r_ferr   <= w_ferr_nxt;
            r_idle   <= (w_state_nxt == S_IDLE);
        end
    end

    // Next-state and datapath decode; the tick counter restarts on every state entry.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bitcnt_nxt = r_bitcnt;
        w_shreg_nxt  = r_shreg;
        w_data_nxt   = r_data;
        w_ready_nxt  = 1'b0;
        w_ferr_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = CNT_ZERO;
                if (!w_rxd_s) begin
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_START: begin
                if (UART_CLK_X16) begin
                    if (r_cnt == MID_START) begin
                        w_cnt_nxt = CNT_ZERO;
                        if (!w_rxd_s) begin
                            w_state_nxt  = S_DATA;
                            w_bitcnt_nxt = 3'd0;
                        end else begin
                            // Start bit did not survive to its midpoint: treat as a glitch.
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end

            S_DATA: begin
                if (UART_CLK_X16) begin
                    if (r_cnt == MID_BIT) begin
                        w_cnt_nxt    = CNT_ZERO;
                        w_shreg_nxt  = {w_rxd_s, r_shreg[7:1]};
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            w_state_nxt = S_STOP;
                        end else begin
                            w_state_nxt = S_DATA;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end

            S_STOP: begin
                if (UART_CLK_X16) begin
                    if (r_cnt == MID_BIT) begin
                        w_cnt_nxt = CNT_ZERO;
                        if (w_rxd_s) begin
                            w_data_nxt  = r_shreg;
                            w_ready_nxt = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = S_WAIT;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end

            S_WAIT: begin
                // A held-low line must return high before another frame is accepted.
                w_cnt_nxt = CNT_ZERO;
                if (w_rxd_s) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    assign DATA       = r_data;
    assign DATA_READY = r_ready;
    assign FRAME_ERR  = r_ferr;
    assign IDLE       = r_idle;

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv: frame table plus hand-written corner sequences.
module tb_uart_recv;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       UART_CLK_X16 = 1'b0;
    logic       RXD = 1'b1;
    logic [7:0] DATA;
    logic       DATA_READY;
    logic       FRAME_ERR;
    logic       IDLE;

    int n_cmp = 0;
    int n_err = 0;
    int tick_per = 2;
    int ph = 0;
    int cyc = 0;
    int rdy_cnt = 0;
    int fe_cnt = 0;
    int viol = 0;
    int rdy_cyc = 0;
    int start_cyc = 0;
    logic prev_rdy = 1'b0;
    logic prev_fe = 1'b0;
    logic [7:0] rx_q[$];

    typedef struct {
        logic [7:0] d;
        logic       stop_v;
        int         hold_low;
        int         idle_after;
        int         exp_rdy;
        int         exp_fe;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    uart_recv #(.OVERSAMPLE(16), .CNT_W(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .UART_CLK_X16(UART_CLK_X16),
        .RXD(RXD),
        .DATA(DATA),
        .DATA_READY(DATA_READY),
        .FRAME_ERR(FRAME_ERR),
        .IDLE(IDLE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    // Oversampling enable: one pulse every tick_per cycles (continuous when 1).
    always @(negedge CLK) begin
        if (tick_per <= 1) begin
            UART_CLK_X16 = 1'b1;
        end else begin
            ph = (ph + 1) % tick_per;
            UART_CLK_X16 = (ph == 0);
        end
    end

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge CLK) begin
        if (DATA_READY) begin
            rdy_cnt++;
            rdy_cyc = cyc;
            rx_q.push_back(DATA);
        end
        if (FRAME_ERR) fe_cnt++;
        if ((DATA_READY && FRAME_ERR) || (DATA_READY && prev_rdy) || (FRAME_ERR && prev_fe)) viol++;
        prev_rdy = DATA_READY;
        prev_fe  = FRAME_ERR;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge CLK);
            if (UART_CLK_X16) k++;
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        @(negedge CLK);
        RXD = v;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        @(negedge CLK);
        RXD = 1'b0;
        start_cyc = cyc;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 16);
        drive_bit(stop_v, 16);
    endtask

    initial begin
        vecs[0] = '{d: 8'h3C, stop_v: 1'b1, hold_low: 0,  idle_after: 20, exp_rdy: 1, exp_fe: 0, exp_data: 8'h3C};
        vecs[1] = '{d: 8'h00, stop_v: 1'b1, hold_low: 0,  idle_after: 0,  exp_rdy: 1, exp_fe: 0, exp_data: 8'h00};
        vecs[2] = '{d: 8'hFF, stop_v: 1'b1, hold_low: 0,  idle_after: 20, exp_rdy: 1, exp_fe: 0, exp_data: 8'hFF};
        vecs[3] = '{d: 8'h55, stop_v: 1'b0, hold_low: 30, idle_after: 20, exp_rdy: 0, exp_fe: 1, exp_data: 8'hFF};
        vecs[4] = '{d: 8'h81, stop_v: 1'b1, hold_low: 0,  idle_after: 20, exp_rdy: 1, exp_fe: 0, exp_data: 8'h81};

        // Reset and idle line
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_idle", {31'd0, IDLE}, 32'd1);
        check("rst_data", {24'd0, DATA}, 32'h00);
        check("rst_ready", {31'd0, DATA_READY}, 32'd0);
        check("rst_ferr", {31'd0, FRAME_ERR}, 32'd0);
        RST = 1'b1;
        wait_ticks(1000);
        check("idle_ready_cnt", rdy_cnt, 32'd0);
        check("idle_ferr_cnt", fe_cnt, 32'd0);
        check("idle_flag", {31'd0, IDLE}, 32'd1);
        check("idle_data", {24'd0, DATA}, 32'h00);

        // Single 0xA5 with exact pulse latency, enable high every cycle
        tick_per = 1;
        wait_ticks(20);
        rdy_cnt = 0;
        send_frame(8'hA5, 1'b1);
        check("a5_ready_cnt", rdy_cnt, 32'd1);
        check("a5_data", {24'd0, DATA}, 32'hA5);
        check("a5_latency", rdy_cyc - start_cyc, 32'd155);
        wait_ticks(4);
        check("a5_idle", {31'd0, IDLE}, 32'd1);

        // Start glitch: low for 4 ticks only
        tick_per = 2;
        wait_ticks(10);
        rdy_cnt = 0;
        fe_cnt = 0;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 20);
        check("glitch_ready_cnt", rdy_cnt, 32'd0);
        check("glitch_ferr_cnt", fe_cnt, 32'd0);
        check("glitch_idle", {31'd0, IDLE}, 32'd1);

        // Frame table: valid, back-to-back, framing error with held-low line
        for (int v = 0; v < 5; v++) begin
            rdy_cnt = 0;
            fe_cnt = 0;
            send_frame(vecs[v].d, vecs[v].stop_v);
            if (!vecs[v].stop_v) begin
                wait_ticks(vecs[v].hold_low);
                @(negedge CLK);
                RXD = 1'b1;
            end
            wait_ticks(vecs[v].idle_after);
            check($sformatf("vec%0d_ready_cnt", v), rdy_cnt, vecs[v].exp_rdy);
            check($sformatf("vec%0d_ferr_cnt", v), fe_cnt, vecs[v].exp_fe);
            check($sformatf("vec%0d_data", v), {24'd0, DATA}, {24'd0, vecs[v].exp_data});
            if (vecs[v].idle_after > 0) check($sformatf("vec%0d_idle", v), {31'd0, IDLE}, 32'd1);
        end

        // Reset asserted in the middle of data bit 4
        rdy_cnt = 0;
        fe_cnt = 0;
        @(negedge CLK);
        RXD = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
        drive_bit(1'b0, 8);
        @(negedge CLK);
        RST = 1'b0;
        RXD = 1'b1;
        #1;
        check("midrst_idle", {31'd0, IDLE}, 32'd1);
        check("midrst_data", {24'd0, DATA}, 32'h00);
        @(negedge CLK);
        RST = 1'b1;
        wait_ticks(40);
        check("midrst_ready_cnt", rdy_cnt, 32'd0);
        check("midrst_ferr_cnt", fe_cnt, 32'd0);
        send_frame(8'h96, 1'b1);
        wait_ticks(10);
        check("postrst_ready_cnt", rdy_cnt, 32'd1);
        check("postrst_data", {24'd0, DATA}, 32'h96);

        // Loopback-style stream of every byte value, back-to-back
        tick_per = 1;
        wait_ticks(20);
        rx_q.delete();
        fe_cnt = 0;
        for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1);
        wait_ticks(10);
        check("loop_count", rx_q.size(), 32'd256);
        for (int i = 0; i < rx_q.size() && i < 256; i++)
            check($sformatf("loop_byte%0d", i), {24'd0, rx_q[i]}, i);
        check("loop_ferr_cnt", fe_cnt, 32'd0);
        check("pulse_exclusive_width", viol, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
